// File: rtl/minibyte_membus_ctrl.sv
// minibyte_membus_ctrl
// External memory bus sequencer for the minibyte CPU. One read or write per
// request over a shared 8-bit pad bus: address phase (ALE), data phase with a
// ready handshake bounded by WAIT_MAX, then a one-cycle completion state.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for req_in; operands captured on acceptance
//   ADDR  | drive latched address with ale_out for one cycle
//   DATA  | rd/wr strobe asserted, wait for ready_in or timeout
//   DONE  | done_out pulse, bus released, back to IDLE next edge

module minibyte_membus_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       req_in,
  input  logic       we_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] wdata_in,
  input  logic [7:0] bus_in,
  input  logic       ready_in,
  output logic [7:0] bus_out,
  output logic       bus_oe_out,
  output logic       ale_out,
  output logic       rd_out,
  output logic       wr_out,
  output logic [7:0] rdata_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Count value reached on the last permitted ready-low DATA cycle.
  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;

  // State and datapath registers; reset abandons any in-flight cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      cnt_q   <= 8'h00;
      rdata_q <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update. Operands only change on acceptance in
  // IDLE, so a request during a cycle is simply ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          we_d    = we_in;
          err_d   = 1'b0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = 8'h00;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ready_in) begin
          if (!we_q) begin
            rdata_d = bus_in;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q != 8'hFF) begin
          // Saturate rather than wrap so a stuck count can never re-arm.
          cnt_d = cnt_q + 8'h01;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from state and latched direction only.
  always_comb begin
    bus_out    = 8'h00;
    bus_oe_out = 1'b0;
    ale_out    = 1'b0;
    rd_out     = 1'b0;
    wr_out     = 1'b0;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state_q)
      ST_ADDR: begin
        bus_out    = addr_q;
        bus_oe_out = 1'b1;
        ale_out    = 1'b1;
        busy_out   = 1'b1;
      end
      ST_DATA: begin
        busy_out = 1'b1;
        if (we_q) begin
          bus_out    = wdata_q;
          bus_oe_out = 1'b1;
          wr_out     = 1'b1;
        end else begin
          rd_out = 1'b1;
        end
      end
      ST_DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
      end
      default: begin
        busy_out = 1'b0;
      end
    endcase
  end

  assign rdata_out = rdata_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_minibyte_membus_ctrl.sv
// Testbench for minibyte_membus_ctrl: directed and randomized bus cycles
// checked against a phase-level reference of the bus protocol.

module tb_minibyte_membus_ctrl;

  localparam int WM = 15;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       req_in;
  logic       we_in;
  logic [7:0] addr_in;
  logic [7:0] wdata_in;
  logic [7:0] bus_in;
  logic       ready_in;
  logic [7:0] bus_out;
  logic       bus_oe_out;
  logic       ale_out;
  logic       rd_out;
  logic       wr_out;
  logic [7:0] rdata_out;
  logic       busy_out;
  logic       done_out;
  logic       err_out;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_rdata;
  logic       exp_err;

  minibyte_membus_ctrl #(.WAIT_MAX(WM)) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_in     (req_in),
    .we_in      (we_in),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .bus_in     (bus_in),
    .ready_in   (ready_in),
    .bus_out    (bus_out),
    .bus_oe_out (bus_oe_out),
    .ale_out    (ale_out),
    .rd_out     (rd_out),
    .wr_out     (wr_out),
    .rdata_out  (rdata_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // One complete bus cycle. delay = number of ready-low DATA cycles before
  // ready goes high; delay >= WM means ready never arrives (timeout).
  task automatic run_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int delay, input logic [7:0] rval, input bit keep_req);
    int  n_data;
    bit  tmo;
    tmo    = (delay >= WM);
    n_data = tmo ? WM : delay + 1;

    req_in   = 1'b1;
    we_in    = we;
    addr_in  = addr;
    wdata_in = wdata;
    ready_in = 1'b0;
    cyc();
    if (!keep_req) req_in = 1'b0;
    chk("addr_ale",  {7'd0, ale_out},    8'd1);
    chk("addr_bus",  bus_out,            addr);
    chk("addr_oe",   {7'd0, bus_oe_out}, 8'd1);
    chk("addr_busy", {7'd0, busy_out},   8'd1);
    chk("addr_err",  {7'd0, err_out},    8'd0);
    chk("addr_strb", {6'd0, rd_out, wr_out}, 8'd0);
    addr_in  = 8'($urandom);
    wdata_in = 8'($urandom);
    we_in    = 1'($urandom);
    ready_in = 1'($urandom);
    cyc();
    for (int k = 0; k < n_data; k++) begin
      chk("data_rd",   {7'd0, rd_out},     {7'd0, ~we});
      chk("data_wr",   {7'd0, wr_out},     {7'd0, we});
      chk("data_oe",   {7'd0, bus_oe_out}, {7'd0, we});
      chk("data_bus",  bus_out,            we ? wdata : 8'h00);
      chk("data_ctl",  {5'd0, ale_out, done_out, busy_out}, 8'd1);
      ready_in = (k == delay);
      bus_in   = (k == delay) ? rval : 8'($urandom);
      cyc();
    end
    if (!we && !tmo) exp_rdata = rval;
    exp_err = tmo;
    chk("done_pulse", {7'd0, done_out},   8'd1);
    chk("done_err",   {7'd0, err_out},    {7'd0, exp_err});
    chk("done_rdata", rdata_out,          exp_rdata);
    chk("done_strb",  {5'd0, ale_out, rd_out, wr_out}, 8'd0);
    chk("done_oe",    {7'd0, bus_oe_out}, 8'd0);
    chk("done_bus",   bus_out,            8'h00);
    chk("done_busy",  {7'd0, busy_out},   8'd1);
    ready_in = 1'($urandom);
    cyc();
    chk("idle_done",  {7'd0, done_out},   8'd0);
    chk("idle_busy",  {7'd0, busy_out},   8'd0);
    chk("idle_err",   {7'd0, err_out},    {7'd0, exp_err});
    chk("idle_rdata", rdata_out,          exp_rdata);
    chk("idle_bus",   {bus_out[7:1], bus_out[0] | bus_oe_out}, 8'h00);
    ready_in = 1'b0;
  endtask

  initial begin
    rst_n_in = 1'b0;
    req_in   = 1'b1;
    we_in    = 1'b1;
    addr_in  = 8'hFF;
    wdata_in = 8'hFF;
    bus_in   = 8'hFF;
    ready_in = 1'b1;
    exp_rdata = 8'h00;
    exp_err   = 1'b0;

    #12;
    chk("rst_bus",   bus_out, 8'h00);
    chk("rst_ctl",   {1'b0, bus_oe_out, ale_out, rd_out, wr_out, busy_out, done_out, err_out}, 8'h00);
    chk("rst_rdata", rdata_out, 8'h00);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Zero-wait write, accepted on the first edge after reset release.
    run_op(1'b1, 8'h3C, 8'hA5, 0, 8'h00, 1'b0);
    // Waited read: three ready-low DATA cycles.
    run_op(1'b0, 8'h80, 8'h00, 3, 8'h5A, 1'b0);
    // Timeout: read with ready never arriving keeps rdata, sets err.
    run_op(1'b0, 8'h44, 8'h00, 40, 8'hEE, 1'b0);
    // Next request clears err (checked in the address phase).
    run_op(1'b1, 8'h11, 8'h22, 14, 8'h00, 1'b0);
    // Boundary: ready on the very last permitted DATA cycle.
    run_op(1'b0, 8'h12, 8'h00, WM - 1, 8'hC3, 1'b0);

    // req held high through back-to-back operations.
    run_op(1'b1, 8'h01, 8'h02, 1, 8'h00, 1'b1);
    run_op(1'b0, 8'h03, 8'h00, 2, 8'h77, 1'b1);
    run_op(1'b1, 8'h05, 8'h06, 0, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(1'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 17)), 8'($urandom), 1'($urandom));
    end
    req_in = 1'b0;
    cyc();

    // Reset in the DATA phase of a write.
    req_in   = 1'b1;
    we_in    = 1'b1;
    addr_in  = 8'h9A;
    wdata_in = 8'hBC;
    ready_in = 1'b0;
    cyc();
    req_in = 1'b0;
    cyc();
    chk("mid_wr_pre", {7'd0, wr_out}, 8'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_ctl", {1'b0, bus_oe_out, ale_out, rd_out, wr_out, busy_out, done_out, err_out}, 8'h00);
    chk("mid_rst_bus", bus_out, 8'h00);
    chk("mid_rst_rdata", rdata_out, 8'h00);
    exp_rdata = 8'h00;
    exp_err   = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", {6'd0, done_out, busy_out}, 8'h00);
    end
    run_op(1'b0, 8'h5F, 8'h00, 1, 8'h3E, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
